// File: rtl/wb_arb_pkg.sv
// Shared constants and helpers for the register-file write-back arbiter.
// Requester index names match the simple CPU's write-back sources.
package wb_arb_pkg;

  localparam int DEF_NUM_REQ    = 3;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_REGS   = 8;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_IMM  = 2;

  // $clog2 yields 0 for 1, which would produce zero-width vectors.
  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: searches i_req starting at i_ptr, wrapping
// modulo NUM_REQ, and returns a one-hot grant and its encoded index.
module rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = clog2_safe(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  int   w_cand;
  logic w_found;

  // NOTE: every output of this block gets a default before the search loop,
  // so no path through it can leave a value unassigned and infer a latch.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_cand = (int'(i_ptr) + off) % NUM_REQ;
      if (i_en && !w_found && i_req[IDX_W'(w_cand)]) begin
        o_grant[IDX_W'(w_cand)] = 1'b1;
        o_idx                   = IDX_W'(w_cand);
        w_found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among write-back
// requesters, with a one-stage write pipeline. Define WB_ARB_FWD_EN to add
// combinational forwarding of the pending write to two read addresses.
module reg_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_WIDTH = clog2_safe(NUM_REGS),
  localparam int GRANT_W   = clog2_safe(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           wb_stall,
  output logic                           write_enable,
  output logic [ADDR_WIDTH-1:0]          write_addr,
  output logic [DATA_WIDTH-1:0]          write_data,
  output logic [GRANT_W-1:0]             grant_id,
  output logic                           busy
`ifdef WB_ARB_FWD_EN
  ,
  input  logic [ADDR_WIDTH-1:0]          fwd_addr1,
  input  logic [ADDR_WIDTH-1:0]          fwd_addr2,
  output logic                           fwd_hit1,
  output logic                           fwd_hit2,
  output logic [DATA_WIDTH-1:0]          fwd_data1,
  output logic [DATA_WIDTH-1:0]          fwd_data2
`endif
);

  logic [GRANT_W-1:0]    r_ptr;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [GRANT_W-1:0]    r_gid;

  logic [GRANT_W-1:0]    w_idx;
  logic [GRANT_W-1:0]    w_ptr_next;
  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Reset gates the grant directly so req_ready is low for the whole reset.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GRANT_W)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (!wb_stall && !reset),
    .o_grant (req_ready),
    .o_idx   (w_idx)
  );

  assign w_xfer     = |req_ready;
  assign w_ptr_next = (w_idx == GRANT_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_ptr_next;
    end
  end

  // An in-flight write is discarded by reset rather than retried.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_gid  <= '0;
    end else begin
      r_we <= w_xfer;
      if (w_xfer) begin
        r_addr <= w_addr_arr[w_idx];
        r_data <= w_data_arr[w_idx];
        r_gid  <= w_idx;
      end
    end
  end

  assign write_enable = r_we;
  assign write_addr   = r_addr;
  assign write_data   = r_data;
  assign grant_id     = r_gid;
  assign busy         = (|req_valid) || r_we;

`ifdef WB_ARB_FWD_EN
  assign fwd_hit1  = r_we && (r_addr == fwd_addr1);
  assign fwd_hit2  = r_we && (r_addr == fwd_addr2);
  assign fwd_data1 = fwd_hit1 ? r_data : '0;
  assign fwd_data2 = fwd_hit2 ? r_data : '0;
`endif

endmodule
